// File: rtl/truth_table_probe.sv
// truth_table_probe
//   Sweeps all eight rows of a 3-input circuit under test, holds each row for
//   SETTLE_CYCLES clocks and captures the circuit's response into an 8-bit
//   truth-table code (row 000 lands in the MSB, so the code reads as the
//   circuit's hex name).
//
// Parameters
//   SETTLE_CYCLES  cycles each row is held before its response is captured (1..255)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   one-cycle sweep request (ignored unless idle)
//   resp   in   response of the circuit under test, synchronous to clk
//   in1    out  row stimulus MSB
//   in2    out  row stimulus middle bit
//   in3    out  row stimulus LSB
//   busy   out  high while a sweep is in progress
//   done   out  one-cycle pulse when code is updated
//   code   out  captured truth-table code
//
// Build option
//   TRUTH_TABLE_PROBE_MAJORITY_EN : when defined, each row's bit is the 2-of-3
//   majority of resp over the last three settle cycles (SETTLE_CYCLES >= 3).
//   When undefined, resp is sampled once on the final settle cycle.
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       resp,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] row_q;
  logic [7:0] settle_q;
  logic [2:0] in_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] code_q;
  logic [7:0] shadow_q;

  logic       sample_bit_d;
  logic [2:0] shadow_idx_d;
  logic [7:0] shadow_d;

`ifdef TRUTH_TABLE_PROBE_MAJORITY_EN
  // Two earlier samples of the current row; the third vote is resp itself
  // on the final settle cycle.
  logic [1:0] vote_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_q <= 2'b00;
    end else if (state_q == DRIVE) begin
      if (settle_q == LAST_SETTLE - 8'd2) vote_q[1] <= resp;
      if (settle_q == LAST_SETTLE - 8'd1) vote_q[0] <= resp;
    end
  end

  always_comb begin
    sample_bit_d = (vote_q[1] & vote_q[0]) | (vote_q[1] & resp) | (vote_q[0] & resp);
  end
`else
  always_comb begin
    sample_bit_d = resp;
  end
`endif

  // Row r is stored at bit 7-r; the merged value is what code takes when
  // the final row is captured.
  always_comb begin
    shadow_idx_d = 3'd7 - row_q;
    shadow_d = shadow_q;
    shadow_d[shadow_idx_d] = sample_bit_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= 3'd0;
      settle_q <= 8'd0;
      in_q     <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 8'h00;
      shadow_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= DRIVE;
            row_q    <= 3'd0;
            settle_q <= 8'd0;
            in_q     <= 3'd0;
            busy_q   <= 1'b1;
            shadow_q <= 8'h00;
          end
        end
        DRIVE: begin
          if (settle_q == LAST_SETTLE) begin
            shadow_q <= shadow_d;
            settle_q <= 8'd0;
            if (row_q == 3'd7) begin
              // Last row captured: publish the code and leave the sweep
              // without wrapping the row counter into a new one.
              state_q <= DONE;
              row_q   <= 3'd0;
              in_q    <= 3'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              code_q  <= shadow_d;
            end else begin
              row_q <= row_q + 3'd1;
              in_q  <= row_q + 3'd1;
            end
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          in_q    <= 3'd0;
        end
      endcase
    end
  end

  assign in1  = in_q[2];
  assign in2  = in_q[1];
  assign in3  = in_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign code = code_q;

endmodule

// File: tb/tb_truth_table_probe.sv
module tb_truth_table_probe;

  localparam int S_A = 4;
`ifdef TRUTH_TABLE_PROBE_MAJORITY_EN
  localparam int S_B = 3;
`else
  localparam int S_B = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
  logic resp_a, resp_b;
  logic in1_a, in2_a, in3_a, busy_a, done_a;
  logic in1_b, in2_b, in3_b, busy_b, done_b;
  logic [7:0] code_a, code_b;

  truth_table_probe #(.SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .resp(resp_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a),
    .busy(busy_a), .done(done_a), .code(code_a)
  );

  truth_table_probe #(.SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .resp(resp_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .busy(busy_b), .done(done_b), .code(code_b)
  );

  always #5 clk = ~clk;

  // cyc = number of the most recent rising edge.  At a falling edge the
  // current cycle is cyc+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Circuit-under-test models: 0 -> 0x34 circuit, 1 -> constant 1, 2 -> constant 0
  int   mode_a = 0;
  int   mode_b = 1;
  logic glitch_a = 1'b0;

  function automatic logic model(input int mode, input logic [2:0] r);
    case (mode)
      0:       return (r == 3'd2) || (r == 3'd3) || (r == 3'd5);
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    resp_a = model(mode_a, {in1_a, in2_a, in3_a}) & ~glitch_a;
    resp_b = model(mode_b, {in1_b, in2_b, in3_b});
  end

  typedef struct {
    logic [7:0] code;
    int         at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc + 1);
  endtask

  // Monitors: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("done_a_unexpected", cyc + 1, -1);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        $display("dut_a done: cycle %0d code 0x%02h (expected cycle %0d code 0x%02h)",
                 cyc + 1, code_a, e.at, e.code);
        chk("code_a", int'(code_a), int'(e.code));
        chk("done_a_cycle", cyc + 1, e.at);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("done_b_unexpected", cyc + 1, -1);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        $display("dut_b done: cycle %0d code 0x%02h (expected cycle %0d code 0x%02h)",
                 cyc + 1, code_b, e.at, e.code);
        chk("code_b", int'(code_b), int'(e.code));
        chk("done_b_cycle", cyc + 1, e.at);
      end
    end
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic sweep_a(output int t);
    start_a = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic sweep_b(output int t);
    start_b = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] c, input int at);
    exp_t e;
    e.code = c;
    e.at   = at;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] c, input int at);
    exp_t e;
    e.code = c;
    e.at   = at;
    q_b.push_back(e);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc + 1 < target) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q_a.size() == 0 && q_b.size() == 0) break;
    end
    chk(name, q_a.size() + q_b.size(), 0);
    // Give any stray done pulse a chance to show up.
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int t, t2;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_done_a", done_a, 0);
    chk("reset_code_a", code_a, 0);
    chk("reset_in_a", {in1_a, in2_a, in3_a}, 0);
    chk("reset_busy_b", busy_b, 0);
    chk("reset_code_b", code_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // 0x34 circuit, SETTLE_CYCLES = 4
    mode_a = 0;
    sweep_a(t);
    push_a(8'h34, t + 1 + 8 * S_A);
    chk("row0_busy_a", busy_a, 1);
    chk("row0_in_a", {in1_a, in2_a, in3_a}, 0);
    wait_cycle(t + 5);
    chk("row1_in_a", {in1_a, in2_a, in3_a}, 1);
    wait_cycle(t + 9);
    chk("row2_in_a", {in1_a, in2_a, in3_a}, 2);
    drain("drain_0x34");
    chk("hold_code_a", code_a, 8'h34);
    chk("idle_busy_a", busy_a, 0);

    // Constant 1 then constant 0 on the short-settle instance
    mode_b = 1;
    sweep_b(t);
    push_b(8'hFF, t + 1 + 8 * S_B);
    drain("drain_ff");
    mode_b = 2;
    sweep_b(t);
    push_b(8'h00, t + 1 + 8 * S_B);
    drain("drain_00");

    // Second start during row 3 is ignored
    mode_a = 0;
    sweep_a(t);
    push_a(8'h34, t + 1 + 8 * S_A);
    wait_cycle(t + 14);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain("drain_restart_ignored");

    // Start during DONE ignored; start in the first IDLE cycle accepted
    sweep_a(t);
    push_a(8'h34, t + 1 + 8 * S_A);
    wait_cycle(t + 1 + 8 * S_A);
    start_a = 1'b1;
    @(negedge clk);
    mode_a = 1;
    sweep_a(t2);
    chk("back_to_back_busy_a", busy_a, 1);
    push_a(8'hFF, t2 + 1 + 8 * S_A);
    drain("drain_back_to_back");

    // Reset in the middle of row 5
    mode_a = 0;
    sweep_a(t);
    wait_cycle(t + 22);
    chk("pre_reset_code_a", code_a, 8'hFF);
    reset = 1'b1;
    #1;
    chk("midreset_busy_a", busy_a, 0);
    chk("midreset_in_a", {in1_a, in2_a, in3_a}, 0);
    chk("midreset_done_a", done_a, 0);
    chk("midreset_code_a", code_a, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("after_reset_code_a", code_a, 0);
    sweep_a(t);
    push_a(8'h34, t + 1 + 8 * S_A);
    drain("drain_after_reset");

    // Glitch on the final settle cycle of row 2
    mode_a = 0;
    sweep_a(t);
`ifdef TRUTH_TABLE_PROBE_MAJORITY_EN
    push_a(8'h34, t + 1 + 8 * S_A);
`else
    push_a(8'h14, t + 1 + 8 * S_A);
`endif
    wait_cycle(t + 12);
    glitch_a = 1'b1;
    @(negedge clk);
    glitch_a = 1'b0;
    drain("drain_glitch");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
